// File: rtl/des_pipe_sequencer_pkg.sv
// Shared types for the DES round-pipeline sequencer: FSM states, default depth,
// and the per-stage control word that rides alongside each block.
package des_pkg;

   localparam int DES_STAGES    = 16;
   // Widest tag a stage register can carry; narrower tags sit in the low bits.
   localparam int DES_TAG_W_MAX = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic                     valid;
      logic                     decrypt;
      logic [DES_TAG_W_MAX-1:0] tag;
   } stage_ctrl_t;

endpackage

// File: rtl/des_pipe_sequencer_if.sv
// Block handshake between serial receiver, sequencer and serial transmitter.
// master = the surrounding environment, slave = the sequencer.
interface des_pipe_sequencer_if #(
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic             in_decrypt;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic             out_decrypt;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_decrypt, in_tag, out_ready,
      input  in_ready, out_valid, out_decrypt, out_tag
   );

   modport slave (
      input  in_valid, in_decrypt, in_tag, out_ready,
      output in_ready, out_valid, out_decrypt, out_tag
   );
endinterface

// File: rtl/des_pipe_sequencer_stage_ctrl.sv
// One control-stage register (valid/mode/tag); loads d when en is high, else holds.
// Latency 1 cycle; no handshake of its own, stalls come in through en.
module des_seq_stage_ctrl
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  stage_ctrl_t d,
   output stage_ctrl_t q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/des_pipe_sequencer.sv
// Sequences STAGES DES round registers: a block accepted at edge k is out_valid after edge k+STAGES-1.
// A held output (out_valid && !out_ready) freezes the whole pipe; DES_SEQ_STATS_EN adds traffic counters.
module des_pipe_sequencer
   import des_pkg::*;
#(
   parameter int STAGES = DES_STAGES,
   parameter int TAG_W  = 4,
   localparam int OCC_W = $clog2(STAGES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   des_pipe_sequencer_if.slave bus,
   input  logic              flush,
   output logic              pipe_en,
   output logic [STAGES-1:0] stage_valid,
   output logic [STAGES-1:0] stage_decrypt,
   output logic [OCC_W-1:0]  occupancy,
   output logic              busy
`ifdef DES_SEQ_STATS_EN
   ,
   output logic [31:0]       blocks_in,
   output logic [31:0]       blocks_out,
   output logic [31:0]       stall_cycles
`endif
);

   seq_state_t       state;
   stage_ctrl_t      stage0_d;
   stage_ctrl_t      stage_q [STAGES];
   logic             last_valid;
   logic             accept;
   logic             fire;
   logic [OCC_W-1:0] occ_nxt;
   logic             unused_tag;

   assign last_valid   = stage_q[STAGES-1].valid;
   assign pipe_en      = !(last_valid && !bus.out_ready);
   assign bus.in_ready = pipe_en && (state != DRAIN) && !flush;
   assign accept       = bus.in_valid && bus.in_ready;
   assign fire         = last_valid && bus.out_ready;

   always_comb begin
      stage0_d                = '0;
      stage0_d.valid          = accept;
      stage0_d.decrypt        = bus.in_decrypt;
      stage0_d.tag[TAG_W-1:0] = bus.in_tag;
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_head
         des_seq_stage_ctrl u_ctrl (
            .clk (clk),
            .rst (rst),
            .en  (pipe_en),
            .d   (stage0_d),
            .q   (stage_q[i])
         );
      end else begin : g_body
         des_seq_stage_ctrl u_ctrl (
            .clk (clk),
            .rst (rst),
            .en  (pipe_en),
            .d   (stage_q[i-1]),
            .q   (stage_q[i])
         );
      end
      assign stage_valid[i]   = stage_q[i].valid;
      assign stage_decrypt[i] = stage_q[i].decrypt;
   end

   assign bus.out_valid   = last_valid;
   assign bus.out_decrypt = stage_q[STAGES-1].decrypt;
   assign bus.out_tag     = stage_q[STAGES-1].tag[TAG_W-1:0];
   // Tag bits above TAG_W are always zero; fold them so they count as consumed.
   assign unused_tag      = ^stage_q[STAGES-1].tag;

   assign occ_nxt   = occupancy + OCC_W'(accept) - OCC_W'(fire);

   // Occupancy only ever returns to zero through RUN/DRAIN, so IDLE always means empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         occupancy <= '0;
      end else begin
         occupancy <= occ_nxt;
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (flush) begin
                  state <= DRAIN;
               end else if (occ_nxt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            DRAIN: begin
               if (occ_nxt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef DES_SEQ_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         blocks_in    <= '0;
         blocks_out   <= '0;
         stall_cycles <= '0;
      end else begin
         blocks_in  <= blocks_in + 32'(accept);
         blocks_out <= blocks_out + 32'(fire);
         if (!pipe_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule
